// File: rtl/vga_pkg.sv
// Shared VGA geometry constants, coordinate widths and the button direction index.
package vga_pkg;

   localparam int unsigned SCREEN_W    = 640;
   localparam int unsigned SCREEN_H    = 480;
   localparam int unsigned SPRITE_SIZE = 50;
   localparam int unsigned X_W         = 10;
   localparam int unsigned Y_W         = 9;

   typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

   // Saturate a signed coordinate into 0..max_v.
   function automatic logic signed [11:0] clamp_pos(input logic signed [11:0] v,
                                                    input logic signed [11:0] max_v);
      if (v < 12'sd0) return 12'sd0;
      if (v > max_v) return max_v;
      return v;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a counter debouncer for one raw push-button.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic db
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1, sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         db    <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == db) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            db  <= ~db;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sprite_position_ctrl.sv
// Per-frame sprite position controller: debounced buttons move a clamped (x, y) once per
// rising edge of screen_end, all in the single system clock domain.
module sprite_position_ctrl
   import vga_pkg::*;
#(
   parameter int unsigned SCREEN_W        = vga_pkg::SCREEN_W,
   parameter int unsigned SCREEN_H        = vga_pkg::SCREEN_H,
   parameter int unsigned SPRITE_SIZE     = vga_pkg::SPRITE_SIZE,
   parameter int unsigned INIT_X          = 50,
   parameter int unsigned INIT_Y          = 50,
   parameter int unsigned STEP            = 1,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           btn_up,
   input  logic           btn_down,
   input  logic           btn_left,
   input  logic           btn_right,
   input  logic           screen_end,
   output logic [X_W-1:0] pos_x,
   output logic [Y_W-1:0] pos_y,
   output logic           pos_update
);

   localparam int unsigned MAX_X   = SCREEN_W - SPRITE_SIZE;
   localparam int unsigned MAX_Y   = SCREEN_H - SPRITE_SIZE;
   localparam int unsigned INIT_XC = (INIT_X > MAX_X) ? MAX_X : INIT_X;
   localparam int unsigned INIT_YC = (INIT_Y > MAX_Y) ? MAX_Y : INIT_Y;

   localparam logic signed [11:0] MAX_X_S = 12'(MAX_X);
   localparam logic signed [11:0] MAX_Y_S = 12'(MAX_Y);
   localparam logic signed [11:0] STEP_S  = 12'(STEP);

   logic [3:0] raw, db;

   assign raw[DIR_UP]    = btn_up;
   assign raw[DIR_DOWN]  = btn_down;
   assign raw[DIR_LEFT]  = btn_left;
   assign raw[DIR_RIGHT] = btn_right;

   for (genvar i = 0; i < 4; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk  (clk),
         .reset(reset),
         .raw  (raw[i]),
         .db   (db[i])
      );
   end

   // Chain resets high so a screen_end already high at reset release is not seen as an edge.
   logic se_s1, se_s2, se_q, tick;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         se_s1 <= 1'b1;
         se_s2 <= 1'b1;
         se_q  <= 1'b1;
         tick  <= 1'b0;
      end else begin
         se_s1 <= screen_end;
         se_s2 <= se_s1;
         se_q  <= se_s2;
         tick  <= se_s2 & ~se_q;
      end
   end

   logic signed [11:0] dx, dy, nx, ny;

   always_comb begin
      dx = 12'sd0;
      dy = 12'sd0;
      if (db[DIR_RIGHT]) dx = dx + STEP_S;
      if (db[DIR_LEFT])  dx = dx - STEP_S;
      if (db[DIR_DOWN])  dy = dy + STEP_S;
      if (db[DIR_UP])    dy = dy - STEP_S;
      nx = signed'({2'b00, pos_x}) + dx;
      ny = signed'({3'b000, pos_y}) + dy;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pos_x      <= X_W'(INIT_XC);
         pos_y      <= Y_W'(INIT_YC);
         pos_update <= 1'b0;
      end else begin
         pos_update <= tick;
         if (tick) begin
            pos_x <= X_W'(clamp_pos(nx, MAX_X_S));
            pos_y <= Y_W'(clamp_pos(ny, MAX_Y_S));
         end
      end
   end

endmodule

// File: tb/tb_sprite_position_ctrl.sv
// Scoreboard bench: two controllers (STEP 1 and STEP 4) share randomized button/frame stimulus.
module tb_sprite_position_ctrl;

   localparam int DC    = 4;
   localparam int MAXX  = 590;
   localparam int MAXY  = 430;
   localparam int BUP   = 1;
   localparam int BDOWN = 2;
   localparam int BLEFT = 4;
   localparam int BRGHT = 8;

   typedef struct {
      int          x;
      int          y;
      int unsigned at;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic se;
   logic [3:0] btn_v;
   logic [9:0] x1, x4;
   logic [8:0] y1, y4;
   logic pu1, pu4;

   int unsigned cyc = 0;
   int checks = 0;
   int failures = 0;

   exp_t q[2][$];
   exp_t e_mon;
   int   mx[2], my[2], lx[2], ly[2];
   int   ax[2], ay[2];
   logic pu[2];
   int   step_sz[2] = '{1, 4};
   int   init_x[2]  = '{50, 49};
   int   init_y[2]  = '{50, 50};
   logic [3:0] mb;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sprite_position_ctrl #(.STEP(1), .DEBOUNCE_CYCLES(DC)) u_dut1 (
      .clk(clk), .reset(reset), .btn_up(btn_v[0]), .btn_down(btn_v[1]),
      .btn_left(btn_v[2]), .btn_right(btn_v[3]), .screen_end(se),
      .pos_x(x1), .pos_y(y1), .pos_update(pu1)
   );

   sprite_position_ctrl #(.STEP(4), .INIT_X(49), .DEBOUNCE_CYCLES(DC)) u_dut4 (
      .clk(clk), .reset(reset), .btn_up(btn_v[0]), .btn_down(btn_v[1]),
      .btn_left(btn_v[2]), .btn_right(btn_v[3]), .screen_end(se),
      .pos_x(x4), .pos_y(y4), .pos_update(pu4)
   );

   always_comb begin
      ax[0] = int'(x1); ay[0] = int'(y1); pu[0] = pu1;
      ax[1] = int'(x4); ay[1] = int'(y4); pu[1] = pu4;
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int clampi(input int v, input int mx_v);
      return (v < 0) ? 0 : ((v > mx_v) ? mx_v : v);
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mx[i] = init_x[i]; my[i] = init_y[i];
         lx[i] = init_x[i]; ly[i] = init_y[i];
         q[i].delete();
      end
   endtask

   // Tick on this rising edge: level-sampled held buttons move each model by its step.
   task automatic push_tick();
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         int dx, dy;
         dx = (mb[3] ? step_sz[i] : 0) - (mb[2] ? step_sz[i] : 0);
         dy = (mb[1] ? step_sz[i] : 0) - (mb[0] ? step_sz[i] : 0);
         mx[i] = clampi(mx[i] + dx, MAXX);
         my[i] = clampi(my[i] + dy, MAXY);
         e.x = mx[i]; e.y = my[i]; e.at = cyc + 4;
         q[i].push_back(e);
      end
   endtask

   // One 100-cycle frame: screen_end high for 20 cycles, buttons change at offset 10,
   // optional short glitch on button gb, optional 1-cycle reset at offset 50.
   task automatic frame(input logic [3:0] nb, input int gl, input int gb, input bit do_rst);
      se = 1'b1;
      push_tick();
      step(10);
      mb    = nb;
      btn_v = nb;
      if (gl > 0) begin
         btn_v[gb] = ~nb[gb];
         step(gl);
         btn_v = nb;
         step(10 - gl);
      end else begin
         step(10);
      end
      se = 1'b0;
      step(30);
      if (do_rst) begin
         reset = 1'b0;
         model_reset();
         #1;
         check("async_rst_x1", int'(x1), 50);
         check("async_rst_y1", int'(y1), 50);
         check("async_rst_x4", int'(x4), 49);
         check("async_rst_upd", int'(pu1), 0);
         step(1);
         reset = 1'b1;
         step(49);
      end else begin
         step(50);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            if (pu[i]) begin
               check($sformatf("update_pending[%0d]", i), int'(q[i].size() > 0), 1);
               if (q[i].size() > 0) begin
                  e_mon = q[i].pop_front();
                  check($sformatf("pos_x[%0d]", i), ax[i], e_mon.x);
                  check($sformatf("pos_y[%0d]", i), ay[i], e_mon.y);
                  check($sformatf("update_cycle[%0d]", i), int'(cyc), int'(e_mon.at));
                  lx[i] = e_mon.x;
                  ly[i] = e_mon.y;
               end
            end else begin
               check($sformatf("hold_x[%0d]", i), ax[i], lx[i]);
               check($sformatf("hold_y[%0d]", i), ay[i], ly[i]);
            end
         end
      end
   end

   initial begin
      int saved;
      reset = 1'b0;
      se    = 1'b1;
      btn_v = '0;
      mb    = '0;
      model_reset();
      step(3);
      check("rst_x1", int'(x1), 50);
      check("rst_y1", int'(y1), 50);
      check("rst_x4", int'(x4), 49);
      check("rst_upd", int'(pu1), 0);
      // Release with screen_end high: the monitor flags any update before the next rise.
      reset = 1'b1;
      step(30);
      se = 1'b0;
      step(70);

      frame(4'd0, 0, 0, 0);
      for (int k = 0; k < 10; k++) frame(4'(BRGHT), 0, 0, 0);
      frame(4'd0, 0, 0, 0);
      check("right10_x1", int'(x1), 60);
      check("right10_y1", int'(y1), 50);

      for (int k = 0; k < 3; k++) frame(4'd0, 3, 0, 0);
      check("glitch_up_y1", int'(y1), 50);

      saved = int'(x1);
      for (int k = 0; k < 5; k++) frame(4'(BLEFT | BRGHT), 0, 0, 0);
      frame(4'd0, 0, 0, 0);
      check("cancel_x1", int'(x1), saved);

      for (int k = 0; k < 30; k++) frame(4'(BLEFT), 0, 0, 0);
      frame(4'd0, 0, 0, 0);
      check("clamp_left_x4", int'(x4), 0);

      for (int k = 0; k < 60; k++) frame(4'(BUP), 0, 0, 0);
      frame(4'd0, 0, 0, 0);
      check("clamp_up_y1", int'(y1), 0);

      for (int k = 0; k < 110; k++) frame(4'(BDOWN), 0, 0, 0);
      frame(4'd0, 0, 0, 0);
      check("clamp_down_y4", int'(y4), MAXY);

      for (int k = 0; k < 30; k++)
         frame(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), 0);

      frame(4'(BRGHT), 0, 0, 1);
      for (int k = 0; k < 3; k++) frame(4'(BRGHT), 0, 0, 0);
      frame(4'd0, 0, 0, 0);
      check("post_rst_x1", int'(x1), 54);

      check("queue_drained", q[0].size() + q[1].size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sprite_position_ctrl.md
# sprite_position_ctrl

Per-frame position controller for the movable on-screen sprite. It turns the four raw push-buttons into a clamped sprite position that the VGA pixel path consumes. The block synchronises and debounces the buttons and detects each frame boundary from the timing generator's `screen_end`. On each boundary it updates a registered `pos_x`/`pos_y` pair, which sits directly upstream of the VGA controller's sprite-compare logic. This replaces ad-hoc position updates clocked off `screen_end`: everything runs on the 100 MHz `clk`.

## Interface
Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- SPRITE_SIZE, 50, sprite edge length in pixels
- INIT_X, 50, reset X position
- INIT_Y, 50, reset Y position
- STEP, 1, pixels moved per frame per axis (1..31)
- DEBOUNCE_CYCLES, 1000000, stable cycles required to accept a button change (10 ms at 100 MHz)

Ports:
- clk  in  1  100 MHz system clock; sole clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- btn_up  in  1  raw asynchronous button
- btn_down  in  1  raw asynchronous button
- btn_left  in  1  raw asynchronous button
- btn_right  in  1  raw asynchronous button
- screen_end  in  1  frame-boundary level from timing generator, sampled in `clk`
- pos_x  out  10  sprite left edge, 0..SCREEN_W-SPRITE_SIZE
- pos_y  out  9  sprite top edge, 0..SCREEN_H-SPRITE_SIZE
- pos_update  out  1  one-cycle pulse when pos_x/pos_y were loaded on a frame tick

## Operation
- Each button passes through a 2-FF synchroniser, then a debouncer.
- Debouncer behaviour:
  - It holds a debounced state `db` and a counter.
  - While the synchronised input equals `db`, the counter is cleared.
  - While it differs, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, `db` toggles and the counter clears.
- Frame tick: `screen_end` is registered as `se_q`; `tick = screen_end_sync & ~se_q`, taken after a 2-FF sync of `screen_end`.
- On tick:
  - dx = (+STEP if right) + (−STEP if left); dy = (+STEP if down) + (−STEP if up).
  - Opposing buttons cancel, giving 0.
  - Compute next = pos + d in signed 12-bit arithmetic.
  - If next < 0, load 0. If next > MAX, load MAX, where MAX_X = SCREEN_W−SPRITE_SIZE and MAX_Y = SCREEN_H−SPRITE_SIZE.
  - Otherwise load next.
- Holding a button moves the sprite STEP pixels every frame. A button pressed and released between two ticks has no effect (level-sampled at tick).
- pos_update pulses on every tick, including when the position is unchanged or clamped.

## Timing
- Reset values:
  - pos_x = INIT_X and pos_y = INIT_Y; both are clamped to MAX at elaboration if larger.
  - pos_update = 0, all `db` = 0, all counters = 0.
  - All synchroniser flops = 0, except the `screen_end` sync chain and `se_q`, which reset to 1. This prevents a spurious tick if `screen_end` is high at reset release.
- Button latency: a raw edge reaches `db` 2 sync cycles + DEBOUNCE_CYCLES cycles later. A glitch shorter than DEBOUNCE_CYCLES never changes `db`.
- Tick latency: `screen_end` rises → tick asserted 3 `clk` cycles later (2 sync + edge register). pos_x, pos_y and pos_update are registered on the cycle after the tick.
- pos_x/pos_y change only on tick cycles and stay stable for the whole frame.
- If `db` changes in the same cycle as a tick, the pre-change `db` is used.
- A reset assertion mid-frame immediately forces the reset values, asynchronously. After release, the first tick requires a fresh `screen_end` rising edge.

## Structure
- Shared package `vga_pkg`: SCREEN_W, SCREEN_H, SPRITE_SIZE, the X/Y width constants (10/9), and the `dir_t` enum {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} used to index the button vector.
- One sub-module `btn_debounce`, parameter DEBOUNCE_CYCLES, ports clk, reset, raw, db. It contains the synchroniser and counter and is instantiated four times.
- The top level holds the frame-edge detector, the adder/clamp datapath and the output registers. The target size is about 150–250 RTL lines in total.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4 and a `screen_end` pulse every 100 cycles.
- Reset release with `screen_end` held high → no pos_update, pos = (50, 50), until the next `screen_end` rising edge.
- Hold btn_right for 10 ticks → pos_x = 60, pos_y = 50, and exactly 10 pos_update pulses, each 1 cycle wide, 4 cycles after each `screen_end` rise.
- A 3-cycle glitch on btn_up → `db` never set, pos_y unchanged across the next 3 ticks.
- Hold btn_left from x = 1 with STEP=4 → next tick x = 0, and subsequent ticks stay at 0. Hold btn_down from y = 428 → y = 430, then stays at 430.
- btn_left and btn_right held together → pos_x constant, pos_update still pulses every tick.
- Assert reset for 1 cycle mid-frame after moving to (70, 20) → outputs return to (50, 50) asynchronously, with no tick until the next `screen_end` rise.
